// File: rtl/round_increment_m.sv
// -----------------------------------------------------------------------------
// round_increment_m
//
// Purpose
//   Final rounding step of a floating-point multiplier. Takes the truncated
//   significand fraction, its biased exponent, sign and the round-up decision,
//   adds one ULP when requested, renormalizes on carry-out, detects overflow to
//   infinity and packs the rounded result. Two-stage elastic pipeline:
//     S1 - increment: M = {1, fraction} + round_flag (SW+2 bits)
//     S2 - renormalize, overflow detection, pack into registered outputs
//
// Handshake (both sides)
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   The producer holds valid and data steady until the transfer, and ready may
//   depend combinationally on the downstream ready (ready_o follows ready_i
//   when both stages are full), so full throughput needs no bubble.
//
// Ports
//   clk, rst      - clock, synchronous active-high reset
//   valid_i       - operand on *_i data ports is valid
//   ready_o       - block accepts the operand this cycle
//   Sgf_Trunc_i   - [SW-1:0] truncated fraction (hidden bit excluded)
//   Exp_i         - [EW-1:0] biased exponent
//   Sign_i        - sign of the result
//   Round_Flag_i  - 1 adds one ULP
//   valid_o       - result on *_o data ports is valid
//   ready_i       - downstream accepts the result
//   Sgf_o         - [SW-1:0] rounded fraction
//   Exp_o         - [EW-1:0] rounded biased exponent
//   Sign_o        - sign, passed through
//   Overflow_o    - rounded result overflowed to infinity
// -----------------------------------------------------------------------------
module round_increment_m #(
  parameter int SW = 23,
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [SW-1:0] Sgf_Trunc_i,
  input  logic [EW-1:0] Exp_i,
  input  logic          Sign_i,
  input  logic          Round_Flag_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [SW-1:0] Sgf_o,
  output logic [EW-1:0] Exp_o,
  output logic          Sign_o,
  output logic          Overflow_o
);

  // All-ones exponent, zero-extended to EW+1 bits so the comparison below
  // also catches Exp_i = all ones with a carry (which would be 2^EW).
  localparam logic [EW:0] EXP_INF = {1'b0, {EW{1'b1}}};

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  logic          s1_valid;
  logic [SW+1:0] s1_m;
  logic [EW-1:0] s1_exp;
  logic          s1_sign;

  logic          s2_valid;
  logic [SW-1:0] s2_sgf;
  logic [EW-1:0] s2_exp;
  logic          s2_sign;
  logic          s2_ovf;

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic in_fire;
  logic s2_load;
  logic s1_load;

  // S2 takes S1's operand when S2 is empty or is being drained this cycle.
  assign s2_load = s1_valid && (!s2_valid || ready_i);
  // S1 may be overwritten when empty or when its operand moves to S2.
  assign s1_load = !s1_valid || s2_load;
  assign ready_o = s1_load;
  assign in_fire = valid_i && ready_o;

  assign valid_o    = s2_valid;
  assign Sgf_o      = s2_sgf;
  assign Exp_o      = s2_exp;
  assign Sign_o     = s2_sign;
  assign Overflow_o = s2_ovf;

  // ---------------------------------------------------------------------------
  // S1 datapath: increment with the hidden bit restored. The extra top bit
  // catches the carry out of an all-ones fraction.
  // ---------------------------------------------------------------------------
  logic [SW+1:0] m_next;

  assign m_next = {2'b01, Sgf_Trunc_i} + {{(SW+1){1'b0}}, Round_Flag_i};

  // ---------------------------------------------------------------------------
  // S2 datapath: renormalize, overflow, pack
  // ---------------------------------------------------------------------------
  logic          carry;
  logic [EW:0]   exp_sum;
  logic          ovf_next;
  logic [SW-1:0] sgf_next;
  logic [EW-1:0] exp_next;

  always_comb begin
    carry    = s1_m[SW+1];
    exp_sum  = {1'b0, s1_exp} + {{EW{1'b0}}, carry};
    // Covers both "result reaches all ones" and "input was already all ones"
    // (the latter gives all ones or 2^EW, both >= EXP_INF).
    ovf_next = (exp_sum >= EXP_INF);
    sgf_next = s1_m[SW-1:0];
    exp_next = exp_sum[EW-1:0];
    if (carry) begin
      // 1.111..1 + ulp = 10.000..0: fraction becomes zero, exponent bumps.
      sgf_next = '0;
    end
    if (ovf_next) begin
      sgf_next = '0;
      exp_next = '1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_m     <= '0;
      s1_exp   <= '0;
      s1_sign  <= 1'b0;
      s2_valid <= 1'b0;
      s2_sgf   <= '0;
      s2_exp   <= '0;
      s2_sign  <= 1'b0;
      s2_ovf   <= 1'b0;
    end else begin
      // S1
      if (s1_load) begin
        s1_valid <= valid_i;
      end
      if (in_fire) begin
        s1_m    <= m_next;
        s1_exp  <= Exp_i;
        s1_sign <= Sign_i;
      end

      // S2: data registers change only on a load, so they hold while stalled.
      if (s2_load) begin
        s2_valid <= 1'b1;
        s2_sgf   <= sgf_next;
        s2_exp   <= exp_next;
        s2_sign  <= s1_sign;
        s2_ovf   <= ovf_next;
      end else if (ready_i) begin
        s2_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_round_increment_m.sv
// -----------------------------------------------------------------------------
// tb_round_increment_m
//
// Self-checking bench for round_increment_m (SW=23, EW=8). Inputs are driven
// 1 time unit after the rising edge; outputs and handshakes are sampled on the
// falling edge. A monitor keeps an occupancy count and an expected queue built
// from an arithmetic reference model, and compares every output transfer in
// order. Directed cases cover the worked examples, backpressure, and reset
// while full; a randomized phase then mixes stalls and boundary operands.
// -----------------------------------------------------------------------------
module tb_round_increment_m;

  localparam int SW = 23;
  localparam int EW = 8;
  localparam int W  = SW + EW + 2;   // {sign, overflow, exp, sgf}

  logic          clk;
  logic          rst;
  logic          valid_i;
  logic          ready_o;
  logic [SW-1:0] Sgf_Trunc_i;
  logic [EW-1:0] Exp_i;
  logic          Sign_i;
  logic          Round_Flag_i;
  logic          valid_o;
  logic          ready_i;
  logic [SW-1:0] Sgf_o;
  logic [EW-1:0] Exp_o;
  logic          Sign_o;
  logic          Overflow_o;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  int           occ = 0;
  bit           last_in_fire = 0;
  bit           prev_stall = 0;
  logic [W-1:0] prev_out = '0;

  round_increment_m #(.SW(SW), .EW(EW)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .Sgf_Trunc_i  (Sgf_Trunc_i),
    .Exp_i        (Exp_i),
    .Sign_i       (Sign_i),
    .Round_Flag_i (Round_Flag_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .Sgf_o        (Sgf_o),
    .Exp_o        (Exp_o),
    .Sign_o       (Sign_o),
    .Overflow_o   (Overflow_o)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h (t=%0t)",
               tag, observed, expected, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: value-level rounding of 1.fraction * 2^exp
  // ---------------------------------------------------------------------------
  function automatic logic [W-1:0] ref_model(input logic [SW-1:0] frac,
                                             input logic [EW-1:0] exp_in,
                                             input logic sign, input logic flag);
    longint sig;
    int     e;
    bit     ovf;
    logic [SW-1:0] r_sgf;
    logic [EW-1:0] r_exp;
    sig = (longint'(1) << SW) + longint'(frac) + longint'(flag);
    e   = int'(exp_in);
    if (sig == (longint'(1) << (SW + 1))) begin
      sig = longint'(1) << SW;   // 2.0 renormalizes to 1.0 with exponent + 1
      e   = e + 1;
    end
    ovf = (e >= (1 << EW) - 1);
    if (ovf) begin
      r_sgf = '0;
      r_exp = '1;
    end else begin
      r_sgf = SW'(sig - (longint'(1) << SW));
      r_exp = EW'(e);
    end
    return {sign, ovf, r_exp, r_sgf};
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [W-1:0] obs;
    obs = {Sign_o, Overflow_o, Exp_o, Sgf_o};
    if (rst) begin
      exp_q.delete();
      occ          = 0;
      prev_stall   = 0;
      last_in_fire = 0;
    end else begin
      check("ready_o", 64'(ready_o), 64'((occ < 2) || ready_i));
      if (prev_stall) check("hold_stable", 64'(obs), 64'(prev_out));
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) check("spurious_out", 64'(1), 64'(0));
        else check("out_data", 64'(obs), 64'(exp_q.pop_front()));
        if (occ > 0) occ--;
      end
      last_in_fire = valid_i && ready_o;
      if (last_in_fire) begin
        exp_q.push_back(ref_model(Sgf_Trunc_i, Exp_i, Sign_i, Round_Flag_i));
        occ++;
      end
      prev_stall = valid_o && !ready_i;
      prev_out   = obs;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst     = 1'b1;
    valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_op(input logic [SW-1:0] frac, input logic [EW-1:0] e,
                        input logic sign, input logic flag);
    valid_i      = 1'b1;
    Sgf_Trunc_i  = frac;
    Exp_i        = e;
    Sign_i       = sign;
    Round_Flag_i = flag;
  endtask

  // Present an operand (call just after a rising edge) and hold it until
  // accepted. Returns just after the accepting edge with valid_i still high.
  task automatic send_wait(input logic [SW-1:0] frac, input logic [EW-1:0] e,
                           input logic sign, input logic flag);
    bit done;
    done = 0;
    set_op(frac, e, sign, flag);
    for (int i = 0; i < 50 && !done; i++) begin
      @(posedge clk); #1;
      done = last_in_fire;
    end
    if (!done) check("accept_timeout", 64'(0), 64'(1));
  endtask

  // One operand through an otherwise empty pipe with ready_i=1: checks the
  // two-cycle latency and the spelled-out result.
  task automatic directed(input string tag, input logic [SW-1:0] frac,
                          input logic [EW-1:0] e, input logic sign,
                          input logic flag, input logic [SW-1:0] x_sgf,
                          input logic [EW-1:0] x_exp, input logic x_ovf);
    ready_i = 1'b1;
    send_wait(frac, e, sign, flag);
    valid_i = 1'b0;
    @(negedge clk);
    check({tag, "_valid_c1"}, 64'(valid_o), 64'(0));
    @(negedge clk);
    check({tag, "_valid_c2"}, 64'(valid_o), 64'(1));
    check({tag, "_sgf"}, 64'(Sgf_o), 64'(x_sgf));
    check({tag, "_exp"}, 64'(Exp_o), 64'(x_exp));
    check({tag, "_sign"}, 64'(Sign_o), 64'(sign));
    check({tag, "_ovf"}, 64'(Overflow_o), 64'(x_ovf));
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst          = 1'b1;
    valid_i      = 1'b0;
    ready_i      = 1'b0;
    Sgf_Trunc_i  = '0;
    Exp_i        = '0;
    Sign_i       = 1'b0;
    Round_Flag_i = 1'b0;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_valid_o", 64'(valid_o), 64'(0));
    check("rst_sgf", 64'(Sgf_o), 64'(0));
    check("rst_exp", 64'(Exp_o), 64'(0));
    check("rst_sign", 64'(Sign_o), 64'(0));
    check("rst_ovf", 64'(Overflow_o), 64'(0));
    check("rst_ready_o", 64'(ready_o), 64'(1));
    @(posedge clk); #1;

    // Worked examples
    directed("plain_round", 23'h000001, 8'h80, 1'b0, 1'b1, 23'h000002, 8'h80, 1'b0);
    directed("carry",       23'h7FFFFF, 8'h80, 1'b0, 1'b1, 23'h000000, 8'h81, 1'b0);
    directed("overflow",    23'h7FFFFF, 8'hFE, 1'b1, 1'b1, 23'h000000, 8'hFF, 1'b1);
    directed("no_round",    23'h7FFFFF, 8'h10, 1'b0, 1'b0, 23'h7FFFFF, 8'h10, 1'b0);
    directed("exp_inf_in",  23'h000123, 8'hFF, 1'b0, 1'b0, 23'h000000, 8'hFF, 1'b1);

    // Backpressure: A and B fill the pipe, C waits at the input
    ready_i = 1'b0;
    send_wait(23'h0000AA, 8'h20, 1'b0, 1'b1);
    send_wait(23'h0000BB, 8'h21, 1'b1, 1'b0);
    set_op(23'h0000CC, 8'h22, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready_low", 64'(ready_o), 64'(0));
      check("bp_valid_o", 64'(valid_o), 64'(1));
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    @(negedge clk);
    check("bp_out_a", 64'(valid_o), 64'(1));
    @(posedge clk); #1;
    check("bp_c_accept", 64'(last_in_fire), 64'(1));
    valid_i = 1'b0;
    @(negedge clk);
    check("bp_out_b", 64'(valid_o), 64'(1));
    @(negedge clk);
    check("bp_out_c", 64'(valid_o), 64'(1));
    @(posedge clk); #1;

    // Reset while both stages are full; an operand offered during reset
    // must not be taken.
    ready_i = 1'b0;
    send_wait(23'h000011, 8'h30, 1'b1, 1'b1);
    send_wait(23'h000022, 8'h31, 1'b1, 1'b1);
    valid_i = 1'b0;
    rst     = 1'b1;
    ready_i = 1'b1;
    set_op(23'h000033, 8'h32, 1'b1, 1'b1);
    @(posedge clk); #1;
    rst     = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    check("rstf_valid_o", 64'(valid_o), 64'(0));
    check("rstf_data", 64'({Sign_o, Overflow_o, Exp_o, Sgf_o}), 64'(0));
    check("rstf_ready_o", 64'(ready_o), 64'(1));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rstf_no_ghost", 64'(valid_o), 64'(0));
    end
    @(posedge clk); #1;

    // Randomized traffic with stalls and boundary-heavy operands
    for (int n = 0; n < 3000; n++) begin
      if (!valid_i || last_in_fire) begin
        logic [SW-1:0] f;
        logic [EW-1:0] e;
        case ($urandom_range(0, 3))
          0:       f = '1;
          1:       f = '0;
          2:       f = {{(SW-1){1'b1}}, 1'b0};
          default: f = SW'($urandom);
        endcase
        case ($urandom_range(0, 4))
          0:       e = 8'hFE;
          1:       e = 8'hFF;
          2:       e = 8'h00;
          default: e = EW'($urandom_range(0, 255));
        endcase
        set_op(f, e, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        valid_i = ($urandom_range(0, 3) != 0);
      end
      ready_i = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end

    // Drain
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
